// File: rtl/multicycle_ctrl_if.sv
// Shared-memory request handshake between the control FSM and memory.
// master = controller side, slave = memory side.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the I-type datapath.
// Define MULTICYCLE_PERF_CNT_EN to build the cycle/instruction counters.
module multicycle_ctrl #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic        zero,
  multicycle_ctrl_if.master mem,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alu_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        instr_done,
  output logic        trap,
  output logic [1:0]  trap_code,
  output logic [2:0]  state,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM_RD = 3'd3;
  localparam logic [2:0] MEM_WR = 3'd4;
  localparam logic [2:0] WB     = 3'd5;
  localparam logic [2:0] BRANCH = 3'd6;
  localparam logic [2:0] TRAP   = 3'd7;

  localparam logic [WAIT_W-1:0] WAIT_LIM =
    WAIT_W'(MAX_WAIT);

  localparam logic [1:0] TC_ILL  = 2'd1;
  localparam logic [1:0] TC_TOUT = 2'd2;

  logic [2:0]        state_q;
  logic [2:0]        state_n;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_n;
  logic [1:0]        code_q;
  logic [1:0]        code_n;

  logic is_beq;
  logic is_bne;
  logic is_alui;
  logic is_lw;
  logic is_sw;
  logic is_br;
  logic is_exec;
  logic taken;
  logic timeout;

  logic req_c;
  logic we_c;
  logic iord_c;
  logic irw_c;
  logic pcw_c;
  logic pcs_c;
  logic alus_c;
  logic rw_c;
  logic m2r_c;
  logic done_c;

  assign is_beq  = opcode == 6'b000100;
  assign is_bne  = opcode == 6'b000101;
  assign is_alui = opcode[5:3] == 3'b001;
  assign is_lw   = opcode == 6'b100011;
  assign is_sw   = opcode == 6'b101011;
  assign is_br   = is_beq | is_bne;
  assign is_exec = is_alui | is_lw | is_sw;

  assign taken = (is_beq & zero)
               | (is_bne & ~zero);

  always_comb begin
    req_c   = 1'b0;
    we_c    = 1'b0;
    iord_c  = 1'b0;
    irw_c   = 1'b0;
    pcw_c   = 1'b0;
    pcs_c   = 1'b0;
    alus_c  = 1'b0;
    rw_c    = 1'b0;
    m2r_c   = 1'b0;
    done_c  = 1'b0;
    state_n = state_q;
    code_n  = code_q;
    unique case (state_q)
      FETCH: begin
        if (run) begin
          req_c = 1'b1;
          if (mem.mem_ready) begin
            irw_c   = 1'b1;
            pcw_c   = 1'b1;
            state_n = DECODE;
          end
        end
      end
      DECODE: begin
        unique case (1'b1)
          is_br:   state_n = BRANCH;
          is_exec: state_n = EXEC;
          default: begin
            state_n = TRAP;
            code_n  = TC_ILL;
          end
        endcase
      end
      EXEC: begin
        alus_c = 1'b1;
        unique case (1'b1)
          is_lw:   state_n = MEM_RD;
          is_sw:   state_n = MEM_WR;
          default: state_n = WB;
        endcase
      end
      MEM_RD: begin
        req_c  = 1'b1;
        iord_c = 1'b1;
        if (mem.mem_ready) state_n = WB;
      end
      MEM_WR: begin
        req_c  = 1'b1;
        iord_c = 1'b1;
        we_c   = 1'b1;
        if (mem.mem_ready) begin
          done_c  = 1'b1;
          state_n = FETCH;
        end
      end
      WB: begin
        rw_c    = 1'b1;
        m2r_c   = is_lw;
        alus_c  = 1'b1;
        done_c  = 1'b1;
        state_n = FETCH;
      end
      BRANCH: begin
        pcw_c   = taken;
        pcs_c   = taken;
        done_c  = 1'b1;
        state_n = FETCH;
      end
      TRAP: begin
        state_n = TRAP;
      end
    endcase
    // a late ready on the last allowed cycle still completes
    if (timeout) begin
      state_n = TRAP;
      code_n  = TC_TOUT;
    end
  end

  assign timeout = req_c
                 & ~mem.mem_ready
                 & (wait_q == WAIT_LIM);

  always_comb begin
    wait_n = wait_q + 1'b1;
    if (state_n != state_q
        || !req_c
        || mem.mem_ready) begin
      wait_n = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_n;
      wait_q  <= wait_n;
      code_q  <= code_n;
    end
  end

  // strobes stay low while reset is held, even in FETCH with run=1
  assign mem.mem_req = req_c  & ~reset;
  assign mem.mem_we  = we_c   & ~reset;
  assign mem.iord    = iord_c & ~reset;
  assign ir_write    = irw_c  & ~reset;
  assign pc_write    = pcw_c  & ~reset;
  assign pc_src      = pcs_c  & ~reset;
  assign alu_src     = alus_c & ~reset;
  assign reg_write   = rw_c   & ~reset;
  assign mem_to_reg  = m2r_c  & ~reset;
  assign instr_done  = done_c & ~reset;

  assign trap      = state_q == TRAP;
  assign trap_code = code_q;
  assign state     = state_q;

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cyc_q;
  logic [31:0] ins_q;
  logic        active;

  assign active = (state_q != TRAP)
               && !(state_q == FETCH && !run);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (active) cyc_q <= cyc_q + 32'd1;
      if (done_c) ins_q <= ins_q + 32'd1;
    end
  end

  assign cycle_count = cyc_q;
  assign instr_count = ins_q;
`else
  assign cycle_count = 32'd0;
  assign instr_count = 32'd0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM sequencing the I-type datapath: instruction memory/PC, register file, ALU, data memory.
- Splits each instruction into FETCH/DECODE/EXEC/MEM/WB steps.
- Drives all datapath enables and muxes.
- Owns a single shared-memory request handshake with a wait-state watchdog.

Parameters:
- WAIT_W, 4: width of the memory wait counter.
- MAX_WAIT, 15: maximum wait cycles for mem_ready before a timeout trap; must be ≤ 2^WAIT_W−1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  allows a new fetch when high.
- opcode  input  6  IR[31:26]; stable from DECODE onward.
- zero  input  1  ALU zero flag (Rs − Rt == 0).
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request.
- mem_we  output  1  write qualifier for mem_req.
- iord  output  1  address select: 0 = PC, 1 = alu_out.
- ir_write  output  1  load IR from memory data.
- pc_write  output  1  load PC.
- pc_src  output  1  PC source: 0 = PC+4, 1 = branch target PC + 4*signExImm.
- alu_src  output  1  ALU B input: 0 = RTvalue, 1 = signExImm.
- reg_write  output  1  write register file at rt.
- mem_to_reg  output  1  register write data: 0 = alu_out, 1 = memory data.
- instr_done  output  1  one-cycle pulse when an instruction retires.
- trap  output  1  sticky error flag.
- trap_code  output  2  trap cause: 0 = none, 1 = illegal opcode, 2 = memory timeout.
- state  output  3  current state encoding.
- cycle_count  output  32  see Optional Feature.
- instr_count  output  32  see Optional Feature.

Behaviour:
- Reset (asynchronous):
  - state = FETCH (0).
  - All outputs 0; wait counter 0; counters 0.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM_RD=3, MEM_WR=4, WB=5, BRANCH=6, TRAP=7.
- Outputs are Moore-decoded from state, except the ready-qualified strobes listed per state.
- Outputs not listed for a state are 0.
- FETCH:
  - If run=0: idle in FETCH with mem_req=0 and the wait counter cleared.
  - If run=1: mem_req=1, iord=0, mem_we=0.
  - On mem_ready=1, same cycle: ir_write=1, pc_write=1, pc_src=0; next state DECODE.
- DECODE (1 cycle), branch on opcode:
  - BEQ 000100, BNE 000101 -> BRANCH.
  - 001xxx (ALU immediate), LW 100011, SW 101011 -> EXEC.
  - Any other opcode -> TRAP with trap_code=1.
- BRANCH (1 cycle):
  - alu_src=0.
  - pc_write=1, pc_src=1 when (BEQ and zero) or (BNE and !zero); otherwise no PC write, since PC already holds PC+4.
  - instr_done=1; next state FETCH.
- EXEC (1 cycle): alu_src=1. Next state MEM_RD for LW, MEM_WR for SW, WB otherwise.
- MEM_RD: mem_req=1, iord=1, mem_we=0. On mem_ready -> WB.
- MEM_WR: mem_req=1, iord=1, mem_we=1. On mem_ready: instr_done=1; next state FETCH.
- WB (1 cycle):
  - reg_write=1; mem_to_reg=1 only for LW.
  - alu_src=1 held so alu_out stays stable.
  - instr_done=1; next state FETCH.
- Latencies with zero wait states:
  - ALU-immediate: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch: 3 cycles.
  - Each wait cycle adds 1.
- Watchdog:
  - The wait counter increments each cycle mem_req=1 and mem_ready=0.
  - It clears on mem_ready and on entering any state.
  - When the counter reaches MAX_WAIT with mem_ready still 0: next state TRAP, trap_code=2.
  - mem_ready in the same cycle wins over timeout.
- TRAP:
  - All strobes 0; trap=1; trap_code holds.
  - Exited only by reset.
- run=0 mid-instruction has no effect; the instruction completes and the FSM then idles in FETCH.
- reset asserted in any state, including mid-handshake, returns to FETCH immediately. The memory must tolerate a dropped request.
- mem_ready while mem_req=0 is ignored.

Optional Feature:
- Macro: MULTICYCLE_PERF_CNT_EN.
- Defined:
  - cycle_count increments every clock while state != TRAP and not idle in FETCH with run=0.
  - instr_count increments on every instr_done.
  - Both 32-bit, wrap 0xFFFFFFFF -> 0, cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- reset, run=1, mem_ready=1 always, opcode=001000 (addi) -> states 0,1,2,5,0; reg_write=1 only in cycle 4; instr_done pulse in cycle 4; mem_to_reg=0.
- LW (100011) with mem_ready low 3 cycles in MEM_RD -> MEM_RD lasts 4 cycles, iord=1, mem_we=0; WB has reg_write=1, mem_to_reg=1; total 8 cycles.
- BEQ with zero=1 then BNE with zero=1 -> first: BRANCH pc_write=1, pc_src=1; second: BRANCH pc_write=0; each 3 cycles.
- opcode=000000 -> TRAP after DECODE, trap=1, trap_code=1; no strobes for 20 cycles; reset clears to FETCH.
- SW with mem_ready never asserted, MAX_WAIT=15 -> 16 cycles in MEM_WR then TRAP, trap_code=2; mem_ready=1 on the 16th cycle instead -> FETCH, no trap.
- MULTICYCLE_PERF_CNT_EN, 3 addi with zero waits, then run=0 -> instr_count=3, cycle_count=12, both frozen while idle.
